// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and the frame-format
// constants agreed with the 8N1 transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_e;

  localparam int unsigned DATA_BITS = 8;
  localparam logic        START_BIT = 1'b0;
  localparam logic        STOP_BIT  = 1'b1;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line; both stages reset
// to 1 so an idle (high) line is assumed while in reset.
module uart_rx_sync (
  input  logic uart_clk_tx,
  input  logic RST_n,
  input  logic async_in,
  output logic sync_out
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = async_in;
    sync_d = meta_q;
  end

  always_ff @(posedge uart_clk_tx) begin
    if (!RST_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign sync_out = sync_q;

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: detects a start bit, samples each bit at its
// middle and hands the word to a valid/ready holding register.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = uart_pkg::DATA_BITS,
  parameter int unsigned OVERSAMPLE = 16,
  parameter bit          MSB_FIRST  = 1'b1,
  parameter logic        STOP_BIT   = uart_pkg::STOP_BIT,
  parameter logic        START_BIT  = uart_pkg::START_BIT
) (
  input  logic                 uart_clk_tx,
  input  logic                 RST_n,
  input  logic                 uart_rx_data,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_busy,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int unsigned SCW = $clog2(OVERSAMPLE);
  localparam int unsigned BCW = $clog2(DATA_BITS + 1);

  localparam logic [SCW-1:0] HALF_LAST = SCW'(OVERSAMPLE / 2 - 1);
  localparam logic [SCW-1:0] BIT_LAST  = SCW'(OVERSAMPLE - 1);
  localparam logic [BCW-1:0] LAST_DATA = BCW'(DATA_BITS - 1);

  logic rx_s;

  uart_state_e          state_q, state_d;
  logic [SCW-1:0]       samp_cnt_q, samp_cnt_d;
  logic [BCW-1:0]       bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;

  uart_rx_sync u_sync (
    .uart_clk_tx (uart_clk_tx),
    .RST_n       (RST_n),
    .async_in    (uart_rx_data),
    .sync_out    (rx_s)
  );

  always_comb begin
    state_d     = state_q;
    samp_cnt_d  = samp_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    frame_err_d = 1'b0;
    overrun_d   = overrun_q;

    if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
      overrun_d  = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (rx_s == START_BIT) begin
          state_d    = START;
          samp_cnt_d = '0;
        end
      end

      START: begin
        if (samp_cnt_q == HALF_LAST) begin
          samp_cnt_d = '0;
          bit_cnt_d  = '0;
          state_d    = (rx_s == START_BIT) ? DATA : IDLE;
        end else begin
          samp_cnt_d = samp_cnt_q + 1'b1;
        end
      end

      DATA: begin
        if (samp_cnt_q == BIT_LAST) begin
          samp_cnt_d = '0;
          bit_cnt_d  = bit_cnt_q + 1'b1;
          if (MSB_FIRST) begin
            shift_d = {shift_q[DATA_BITS-2:0], rx_s};
          end else begin
            shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          end
          if (bit_cnt_q == LAST_DATA) begin
            state_d = STOP;
          end
        end else begin
          samp_cnt_d = samp_cnt_q + 1'b1;
        end
      end

      STOP: begin
        if (samp_cnt_q == BIT_LAST) begin
          samp_cnt_d = '0;
          bit_cnt_d  = '0;
          state_d    = IDLE;
          // A good word only overwrites the holding register if it is free
          // or being drained this very cycle; otherwise it is dropped.
          if (rx_s == STOP_BIT) begin
            if (!rx_valid_q || rx_ready) begin
              rx_data_d  = shift_q;
              rx_valid_d = 1'b1;
            end else begin
              overrun_d = 1'b1;
            end
          end else begin
            frame_err_d = 1'b1;
          end
        end else begin
          samp_cnt_d = samp_cnt_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge uart_clk_tx) begin
    if (!RST_n) begin
      state_q     <= IDLE;
      samp_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      samp_cnt_q  <= samp_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign rx_busy   = (state_q != IDLE);
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule
